// File: rtl/instant_access_memory.sv
// instant_access_memory: 2^N x 2^N array of W-bit words with registered
// reads, single-cycle writes, a zero-fill sweep after reset, and Rd/Wr
// conflict detection.
// Optional feature macro: PARITY_EN (stores an even-parity bit per word and
// flags parity errors on read through err).
module instant_access_memory #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Rd,
    input  logic         Wr,
    input  logic [N-1:0] row,
    input  logic [N-1:0] column,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         valid,
    output logic         enable,
    output logic         busy,
    output logic         err
);

    localparam int unsigned AW    = 2 * N;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef PARITY_EN
    localparam int unsigned SW = W + 1;
`else
    localparam int unsigned SW = W;
`endif

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_out_q, data_out_d;
    logic            valid_q, valid_d;
    logic            enable_q, enable_d;
    logic            err_q, err_d;

    logic [SW-1:0]   mem_q [DEPTH];

    logic            we;
    logic [AW-1:0]   waddr;
    logic [SW-1:0]   wdata;

    logic [AW-1:0]   idx;
    logic [SW-1:0]   rd_word;
    logic [SW-1:0]   wr_word;
    logic            rd_par_err;

    assign idx     = {row, column};
    assign rd_word = mem_q[idx];

`ifdef PARITY_EN
    // Stored word is {parity, data}; the whole word XORs to 0 when intact.
    assign wr_word    = {^data_in, data_in};
    assign rd_par_err = ^rd_word;
`else
    assign wr_word    = data_in;
    assign rd_par_err = 1'b0;
`endif

    // Next-state, sweep counter, memory write port and output pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        enable_d   = 1'b0;
        err_d      = 1'b0;
        we         = 1'b0;
        waddr      = idx;
        wdata      = wr_word;

        unique case (state_q)
            INIT: begin
                // Requests are ignored while sweeping; one word zeroed per cycle.
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (Wr && !Rd) begin
                    we       = 1'b1;
                    enable_d = 1'b1;
                end else if (Rd && !Wr) begin
                    data_out_d = rd_word[W-1:0];
                    valid_d    = 1'b1;
                    enable_d   = 1'b1;
                    err_d      = rd_par_err;
                end else if (Rd && Wr) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            enable_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            enable_q   <= enable_d;
            err_q      <= err_d;
        end
    end

    // Array write port; reset has priority, so no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign enable   = enable_q;
    assign err      = err_q;
    assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_instant_access_memory.sv
// Self-checking bench for instant_access_memory (N=2, W=8).
module tb_instant_access_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Rd = 1'b0;
    logic       Wr = 1'b0;
    logic [1:0] row = '0;
    logic [1:0] column = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       valid;
    logic       enable;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining sweep cycles, word contents, expected outputs.
    int         sweep_left = 16;
    logic [7:0] ref_mem [16];
    logic [7:0] exp_dout = '0;
    logic       exp_valid = 1'b0;
    logic       exp_enable = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_busy = 1'b1;

    instant_access_memory #(.N(2), .W(8)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .row(row), .column(column),
        .data_in(data_in), .data_out(data_out), .valid(valid),
        .enable(enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one edge, update the model from the inputs sampled there,
    // and leave time 1 unit past the edge for sampling.
    task automatic tick();
        int a;
        @(posedge clk);
        a = {row, column};
        exp_valid = 1'b0;
        exp_enable = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            sweep_left = 16;
            exp_dout = 8'h00;
        end else if (sweep_left > 0) begin
            ref_mem[16 - sweep_left] = 8'h00;
            sweep_left--;
        end else if (Wr && !Rd) begin
            ref_mem[a] = data_in;
            exp_enable = 1'b1;
        end else if (Rd && !Wr) begin
            exp_dout = ref_mem[a];
            exp_valid = 1'b1;
            exp_enable = 1'b1;
        end else if (Rd && Wr) begin
            exp_err = 1'b1;
        end
        exp_busy = (sweep_left > 0);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input int a, input logic [7:0] d);
        Rd = r;
        Wr = w;
        {row, column} = a[3:0];
        data_in = d;
    endtask

    task automatic test_reset();
        int n;
        drive(0, 0, 0, 8'h00);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0 || enable !== 1'b0 || err !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got busy=%b valid=%b enable=%b err=%b dout=%h exp 1 0 0 0 00",
                     busy, valid, enable, err, data_out);
        end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_sweep_len got %0d exp 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, 8'h00);
            tick();
            checks++;
            if (data_out !== 8'h00 || valid !== 1'b1) begin
                errors++;
                $display("FAIL reset_zero[%0d] got dout=%h valid=%b exp 00 1", i, data_out, valid);
            end
        end
        drive(0, 0, 0, 8'h00);
        tick();
    endtask

    task automatic test_write_read();
        drive(0, 1, 9, 8'hA5);  // row=2, column=1
        tick();
        checks++;
        if (enable !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse got enable=%b valid=%b err=%b exp 1 0 0", enable, valid, err);
        end
        drive(1, 0, 9, 8'h00);
        tick();
        checks++;
        if (data_out !== 8'hA5 || valid !== 1'b1 || enable !== 1'b1) begin
            errors++;
            $display("FAIL wr_then_rd got dout=%h valid=%b enable=%b exp a5 1 1", data_out, valid, enable);
        end
        drive(0, 0, 0, 8'h00);
        tick();
        checks++;
        if (data_out !== 8'hA5 || valid !== 1'b0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold got dout=%h valid=%b enable=%b exp a5 0 0", data_out, valid, enable);
        end
    endtask

    task automatic test_conflict();
        drive(0, 1, 5, 8'h3C);
        tick();
        drive(1, 1, 5, 8'hFF);
        tick();
        checks++;
        if (err !== 1'b1 || valid !== 1'b0 || enable !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL conflict got err=%b valid=%b enable=%b dout=%h exp 1 0 0 a5",
                     err, valid, enable, data_out);
        end
        drive(0, 0, 0, 8'h00);
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pulse got err=%b exp 0", err);
        end
        drive(1, 0, 5, 8'h00);
        tick();
        checks++;
        if (data_out !== 8'h3C || valid !== 1'b1) begin
            errors++;
            $display("FAIL conflict_kept got dout=%h valid=%b exp 3c 1", data_out, valid);
        end
        drive(0, 0, 0, 8'h00);
        tick();
    endtask

    task automatic test_busy_lockout();
        int n;
        int stray;
        stray = 0;
        drive(0, 0, 0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1, 3, 8'h77);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (enable !== 1'b0 || err !== 1'b0 || busy !== 1'b1) stray++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1, 15, 8'h77);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            if (enable !== 1'b0 || err !== 1'b0) stray++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL midreset_sweep_len got %0d exp 16", n);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL busy_lockout got %0d stray pulses exp 0", stray);
        end
        drive(1, 0, 3, 8'h00);
        tick();
        checks++;
        if (data_out !== 8'h00 || valid !== 1'b1) begin
            errors++;
            $display("FAIL lockout_word3 got dout=%h valid=%b exp 00 1", data_out, valid);
        end
        drive(1, 0, 15, 8'h00);
        tick();
        checks++;
        if (data_out !== 8'h00 || valid !== 1'b1) begin
            errors++;
            $display("FAIL lockout_word15 got dout=%h valid=%b exp 00 1", data_out, valid);
        end
        drive(0, 0, 0, 8'h00);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 8'(i));
            tick();
            checks++;
            if (enable !== 1'b1 || valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wr[%0d] got enable=%b valid=%b exp 1 0", i, enable, valid);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, 8'h00);
            tick();
            checks++;
            if (valid !== 1'b1 || data_out !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_rd[%0d] got valid=%b dout=%h exp 1 %h", i, valid, data_out, 8'(i));
            end
        end
        drive(0, 0, 0, 8'h00);
        tick();
        checks++;
        if (valid !== 1'b0 || data_out !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_end got valid=%b dout=%h exp 0 0f", valid, data_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), 8'($urandom));
            tick();
            checks++;
            if (data_out !== exp_dout || valid !== exp_valid || enable !== exp_enable ||
                err !== exp_err || busy !== exp_busy) begin
                errors++;
                $display("FAIL random[%0d] got dout=%h v=%b en=%b err=%b busy=%b exp %h %b %b %b %b",
                         i, data_out, valid, enable, err, busy,
                         exp_dout, exp_valid, exp_enable, exp_err, exp_busy);
            end
        end
        rst = 1'b0;
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL random_settle got busy=%b exp 0", busy);
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        drive(0, 1, 4, 8'h01);
        tick();
        drive(0, 0, 0, 8'h00);
        tick();
        dut.mem_q[4][0] = ~dut.mem_q[4][0];
        drive(1, 0, 4, 8'h00);
        tick();
        checks++;
        if (err !== 1'b1 || valid !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL parity got err=%b valid=%b dout=%h exp 1 1 00", err, valid, data_out);
        end
        drive(0, 0, 0, 8'h00);
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_conflict();
        test_busy_lockout();
        test_back_to_back();
        test_random();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instant_access_memory.md
# instant_access_memory

Parametrised, clocked word-addressable memory array of 2^N rows by 2^N columns of W-bit words, with registered reads, single-cycle writes, an automatic zero-initialisation sweep after reset, and conflict detection. It is the array-level successor to the single memory cell. It sits between the address decoder/controller and the data path, and gives the controller a busy/valid handshake instead of level-sensitive access.

## Interface
- N, default 2: row and column address width; depth = 2^(2N) words.
- W, default 8: data word width.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Rd  input  1  read request, sampled at the rising edge.
- Wr  input  1  write request, sampled at the rising edge.
- row  input  N  row address.
- column  input  N  column address.
- data_in  input  W  write data.
- data_out  output  W  registered read data; holds the last read value.
- valid  output  1  one-cycle pulse: data_out carries the result of the read accepted on the previous edge.
- enable  output  1  one-cycle pulse after any accepted read or write.
- busy  output  1  high while the array cannot accept requests (INIT).
- err  output  1  one-cycle pulse on a request conflict, or a parity error when PARITY_EN is defined.

Clocking: one clock; reset is synchronous and active-high.

## Operation
- Word index = {row, column}, 2N bits; every index is in range.
- FSM states:
  - INIT: a 2N-bit counter sweeps from 0 to 2^(2N)-1, writing zero to one word per cycle. After the last word is written, the FSM moves to IDLE.
  - IDLE: accepts requests.
- Reset puts the FSM in INIT and clears the counter. It also clears data_out, valid, enable and err, and forces busy=1. Reset asserted mid-sweep or mid-access restarts the sweep; it has priority over all requests.
- Requests (Rd or Wr) sampled while busy=1 are ignored. They raise no err and no enable.
- In IDLE, the action depends on Rd and Wr at the edge:
  - Wr=1, Rd=0: mem[index] <= data_in at that edge; enable pulses next cycle.
  - Rd=1, Wr=0: data_out <= mem[index] at that edge; valid and enable pulse next cycle.
  - Rd=1, Wr=1: conflict. No access is performed, memory and data_out are unchanged, and err pulses next cycle.
  - Rd=0, Wr=0: no action.
- A write followed by a read to the same address on the next edge returns the new data. Memory state is not read-during-write-ambiguous, because same-edge read+write is a conflict.
- Back-to-back accesses on every edge are permitted, with full throughput of 1 access/cycle.

## Timing
- Reset release to busy=0: exactly 2^(2N) cycles. For N=2, busy falls on the 16th rising edge after the first edge with rst=0.
- Write latency: 0. The data is stored at the accepting edge.
- Read latency: 1. data_out and valid update at the accepting edge and are visible in the following cycle.
- valid, enable and err are each high for exactly one cycle per event. They are low in any cycle following an edge with no accepted event.
- data_out is not cleared after a read. It changes only on an accepted read or on reset.

## Configuration
- Macro PARITY_EN.
- Defined:
  - Each word stores W+1 bits, the data plus an even-parity bit computed at write.
  - The INIT sweep writes parity 0.
  - On a read, if the recomputed parity mismatches, err pulses together with valid. data_out still presents the stored data.
- Undefined:
  - Storage is W bits and no parity is computed.
  - err pulses only on conflicts.
  - The port list is identical in both cases.

## Test plan
- Reset sweep: assert rst for 2 cycles, then release. Require busy=1 for exactly 16 cycles (N=2), then busy=0, and every word reads 0x00 with valid=1.
- Write/read: write 0xA5 to row=2, column=1, then read the same address on the next edge. Require data_out=0xA5, with valid=1 and enable=1 for one cycle.
- Conflict: write 0x3C to address 5, then assert Rd=Wr=1 with data_in=0xFF at address 5. Require err=1 for one cycle, valid=0, and a later read of address 5 to return 0x3C.
- Busy lockout and mid-op reset:
  - Issue Wr with 0x77 during INIT. Require that the word reads 0x00 afterwards and that enable was never asserted.
  - Assert rst for 1 cycle after 8 sweep cycles. Require the sweep to restart, with busy held for 16 more cycles.
- Throughput: write addresses 0..15 with data equal to the address on 16 consecutive edges, then read them on 16 consecutive edges. Require valid to stay high for 16 cycles and data_out to step through 0x00..0x0F.
- PARITY_EN: write 0x01, then flip the stored data bit hierarchically and read. Require err=1 coincident with valid=1, and data_out=0x00.
